// File: rtl/posit8_pkg.sv
// Shared types and constants for the posit8 (es=0) multiply front end.
package posit8_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DEC_A = 3'd1,
    DEC_B = 3'd2,
    MUL   = 3'd3,
    DONE  = 3'd4
  } mulState_t;

  localparam logic [7:0] POSIT8_ZERO = 8'h00;
  localparam logic [7:0] POSIT8_NAR  = 8'h80;

  localparam int SCALE_W = 5;
  localparam int FRAC_W  = 6;
  localparam int PROD_W  = 12;
  localparam int DEC_E_W = 4;

endpackage

// File: rtl/decode_posit8.sv
// Combinational posit8 (es=0) decoder: |value| = F * 2^(E-5), F is <1.5> with hidden bit.
// Zero and NaR are not flagged here; callers detect them from the raw operand.
module decode_posit8
  import posit8_pkg::*;
(
  input  logic [7:0]         x_i,
  output logic               s_o,
  output logic [DEC_E_W-1:0] e_o,
  output logic [FRAC_W-1:0]  f_o
);

  logic [6:0]  body;
  logic [3:0]  runLen;
  logic        runStop;
  logic [11:0] shifted;

  always_comb begin
    s_o     = x_i[7];
    body    = x_i[7] ? 7'(~x_i[6:0] + 7'd1) : x_i[6:0];
    runLen  = 4'd1;
    runStop = 1'b0;
    for (int i = 5; i >= 0; i--) begin
      if (!runStop && (body[i] == body[6])) begin
        runLen = runLen + 4'd1;
      end else begin
        runStop = 1'b1;
      end
    end
    // A run of ones gives k = run-1, a run of zeros gives k = -run.
    e_o     = body[6] ? (runLen - 4'd1) : (4'd0 - runLen);
    shifted = {body, 5'b00000} << (runLen + 4'd1);
    f_o     = {1'b1, shifted[11:7]};
  end

endmodule

// File: rtl/posit8_mul_seq.sv
// Multi-cycle posit8 multiply front end sharing one decoder across both operands.
// Optional POSIT8_SPECIAL_BYPASS_EN: zero/NaR pairs skip straight from DEC_A to DONE.
module posit8_mul_seq
  import posit8_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7:0]         in_a,
  input  logic [7:0]         in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               res_s,
  output logic [SCALE_W-1:0] res_e,
  output logic [FRAC_W-1:0]  res_f,
  output logic               res_sticky,
  output logic               res_zero,
  output logic               res_nar,
  output logic [CNT_W-1:0]   ops_done
);

  mulState_t state_q, state_d;

  logic [7:0]         opA_q, opA_d, opB_q, opB_d;
  logic               sa_q, sa_d, sb_q, sb_d;
  logic [DEC_E_W-1:0] ea_q, ea_d, eb_q, eb_d;
  logic [FRAC_W-1:0]  fa_q, fa_d, fb_q, fb_d;

  logic               resS_q, resS_d;
  logic [SCALE_W-1:0] resE_q, resE_d;
  logic [FRAC_W-1:0]  resF_q, resF_d;
  logic               resSticky_q, resSticky_d;
  logic               resZero_q, resZero_d;
  logic               resNar_q, resNar_d;
  logic [CNT_W-1:0]   opsDone_q, opsDone_d;

  logic [7:0]         decIn;
  logic               decS;
  logic [DEC_E_W-1:0] decE;
  logic [FRAC_W-1:0]  decF;

  logic               isNar, isZero;
  logic [PROD_W-1:0]  prod;
  logic [SCALE_W-1:0] scaleSum;

  assign decIn = (state_q == DEC_B) ? opB_q : opA_q;

  decode_posit8 uDecode (
    .x_i (decIn),
    .s_o (decS),
    .e_o (decE),
    .f_o (decF)
  );

  // NaR dominates zero; both come from the raw latched operands.
  assign isNar    = (opA_q == POSIT8_NAR) || (opB_q == POSIT8_NAR);
  assign isZero   = !isNar && ((opA_q == POSIT8_ZERO) || (opB_q == POSIT8_ZERO));
  assign prod     = PROD_W'(fa_q) * PROD_W'(fb_q);
  assign scaleSum = {ea_q[DEC_E_W-1], ea_q} + {eb_q[DEC_E_W-1], eb_q}
                  + (prod[PROD_W-1] ? 5'd1 : 5'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      opA_q       <= '0;
      opB_q       <= '0;
      sa_q        <= 1'b0;
      sb_q        <= 1'b0;
      ea_q        <= '0;
      eb_q        <= '0;
      fa_q        <= '0;
      fb_q        <= '0;
      resS_q      <= 1'b0;
      resE_q      <= '0;
      resF_q      <= '0;
      resSticky_q <= 1'b0;
      resZero_q   <= 1'b0;
      resNar_q    <= 1'b0;
      opsDone_q   <= '0;
    end else begin
      state_q     <= state_d;
      opA_q       <= opA_d;
      opB_q       <= opB_d;
      sa_q        <= sa_d;
      sb_q        <= sb_d;
      ea_q        <= ea_d;
      eb_q        <= eb_d;
      fa_q        <= fa_d;
      fb_q        <= fb_d;
      resS_q      <= resS_d;
      resE_q      <= resE_d;
      resF_q      <= resF_d;
      resSticky_q <= resSticky_d;
      resZero_q   <= resZero_d;
      resNar_q    <= resNar_d;
      opsDone_q   <= opsDone_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    opA_d       = opA_q;
    opB_d       = opB_q;
    sa_d        = sa_q;
    sb_d        = sb_q;
    ea_d        = ea_q;
    eb_d        = eb_q;
    fa_d        = fa_q;
    fb_d        = fb_q;
    resS_d      = resS_q;
    resE_d      = resE_q;
    resF_d      = resF_q;
    resSticky_d = resSticky_q;
    resZero_d   = resZero_q;
    resNar_d    = resNar_q;
    opsDone_d   = opsDone_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          opA_d   = in_a;
          opB_d   = in_b;
          state_d = DEC_A;
        end
      end
      DEC_A: begin
        sa_d    = decS;
        ea_d    = decE;
        fa_d    = decF;
        state_d = DEC_B;
`ifdef POSIT8_SPECIAL_BYPASS_EN
        if (isNar || isZero) begin
          resS_d      = 1'b0;
          resE_d      = '0;
          resF_d      = '0;
          resSticky_d = 1'b0;
          resZero_d   = isZero;
          resNar_d    = isNar;
          state_d     = DONE;
        end
`endif
      end
      DEC_B: begin
        sb_d    = decS;
        eb_d    = decE;
        fb_d    = decF;
        state_d = MUL;
      end
      MUL: begin
        resZero_d = isZero;
        resNar_d  = isNar;
        if (isNar || isZero) begin
          resS_d      = 1'b0;
          resE_d      = '0;
          resF_d      = '0;
          resSticky_d = 1'b0;
        end else begin
          resS_d = sa_q ^ sb_q;
          resE_d = scaleSum;
          // Product lies in [1,4): renormalise by one bit when it reached 2.
          if (prod[PROD_W-1]) begin
            resF_d      = prod[11:6];
            resSticky_d = |prod[5:0];
          end else begin
            resF_d      = prod[10:5];
            resSticky_d = |prod[4:0];
          end
        end
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          opsDone_d = opsDone_q + 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign res_s      = resS_q;
  assign res_e      = resE_q;
  assign res_f      = resF_q;
  assign res_sticky = resSticky_q;
  assign res_zero   = resZero_q;
  assign res_nar    = resNar_q;
  assign ops_done   = opsDone_q;

endmodule
